// File: rtl/axi_slice_pkg.sv
// Shared limits and width helpers for the axi_slice elastic buffer.
package axi_slice_pkg;

  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 256;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_slice_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module axi_slice_mem
  import axi_slice_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_w(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [ptr_w(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_slice_fifo.sv
// DEPTH-entry valid/ready elastic buffer with registered outputs, flush, level and almost-full.
module axi_slice_fifo
  import axi_slice_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(AFULL_LEVEL);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
    $error("axi_slice_fifo: DEPTH out of range");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_afull_chk
    $error("axi_slice_fifo: AFULL_LEVEL out of range");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  afull_q, afull_d;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  push, pop, wr_en;

  assign push        = in_valid & in_ready_q;
  assign pop         = out_valid_q & out_ready;
  assign wr_en       = push & ~flush;
  assign rd_ptr_next = ptr_inc(rd_ptr_q);

  // Every word lands in the array; out_data mirrors the entry at rd_ptr.
  axi_slice_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_next),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = rd_ptr_next;
      if (push && !pop) begin
        level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LVL_ONE;
      end
      // Next head comes from the array when one is queued behind, else straight from in_data.
      if (pop) begin
        if (level_q > LVL_ONE) begin
          out_data_d = mem_rd_data;
        end else if (push) begin
          out_data_d = in_data;
        end
      end else if (!out_valid_q && push) begin
        out_data_d = in_data;
      end
      out_valid_d = (level_d != '0);
    end
    in_ready_d = (level_d < LVL_FULL);
    afull_d    = (level_d >= LVL_AFULL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      afull_q     <= afull_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign level       = level_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_axi_slice_fifo.sv
// Directed and scoreboard checks of axi_slice_fifo at DEPTH 2, 4 (AFULL 3) and 3.
module tb_axi_slice_fifo;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // a: DEPTH=2, b: DEPTH=4/AFULL=3, c: DEPTH=3
  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0, a_in_ready, a_out_valid, a_af;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [1:0]  a_level;
  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0, b_in_ready, b_out_valid, b_af;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [2:0]  b_level;
  logic        c_flush = 0, c_in_valid = 0, c_out_ready = 0, c_in_ready, c_out_valid, c_af;
  logic [31:0] c_in_data = 0, c_out_data;
  logic [1:0]  c_level;

  axi_slice_fifo #(.DATA_WIDTH(32), .DEPTH(2), .AFULL_LEVEL(1)) u_a (
    .clk(clk), .rstn(rstn), .flush(a_flush), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .level(a_level), .almost_full(a_af)
  );
  axi_slice_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_LEVEL(3)) u_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .level(b_level), .almost_full(b_af)
  );
  axi_slice_fifo #(.DATA_WIDTH(32), .DEPTH(3), .AFULL_LEVEL(2)) u_c (
    .clk(clk), .rstn(rstn), .flush(c_flush), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .level(c_level), .almost_full(c_af)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] held;
  logic        stall_prev, do_push, do_pop;
  int          pushed, cyc;

  initial begin
    // Reset with producers asserting valid
    a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
    repeat (3) step();
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_level", a_level, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_af_b", b_af, 0);
    rstn = 1;
    step();
    check("rel_in_ready", a_in_ready, 1);
    check("rel_level", a_level, 0);
    check("rel_out_valid", a_out_valid, 0);
    check("rel_level_c", c_level, 0);
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;

    // Single word through DEPTH=2
    a_in_data = 32'hA5A5_0001; a_in_valid = 1; a_out_ready = 1;
    step();
    a_in_valid = 0;
    check("single_valid", a_out_valid, 1);
    check("single_data", a_out_data, 32'hA5A5_0001);
    check("single_level1", a_level, 1);
    step();
    check("single_level0", a_level, 0);
    check("single_empty", a_out_valid, 0);

    // Streaming, 100 words, no bubbles
    a_in_valid = 1; a_out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      a_in_data = 32'h100 + i;
      step();
      check("stream_valid", a_out_valid, 1);
      check("stream_data", a_out_data, 32'h100 + i);
      check("stream_level", a_level, 1);
    end
    a_in_valid = 0;
    step();
    check("stream_drained", a_level, 0);
    a_out_ready = 0;

    // Fill / drain DEPTH=4, AFULL=3
    for (int i = 1; i <= 4; i++) begin
      b_in_data = i; b_in_valid = 1;
      step();
      check("fill_level", b_level, i);
      check("fill_af", b_af, (i >= 3));
      check("fill_in_ready", b_in_ready, (i < 4));
    end
    check("full_hold", b_level, 4);  // in_valid still high while full
    step();
    check("full_no_push", b_level, 4);
    b_in_valid = 0;
    b_out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_valid", b_out_valid, 1);
      check("drain_data", b_out_data, k);
      step();
      if (k == 1) check("drain_ready_after_pop", b_in_ready, 1);
    end
    check("drain_empty", b_out_valid, 0);
    check("drain_level", b_level, 0);
    check("drain_af", b_af, 0);
    b_out_ready = 0;

    // Flush at level 3 drops the word offered in the same cycle
    for (int i = 0; i < 3; i++) begin
      b_in_data = 32'h11 * (i + 1); b_in_valid = 1;
      step();
    end
    check("pre_flush_level", b_level, 3);
    b_flush = 1; b_in_data = 32'h99;
    step();
    b_flush = 0;
    check("flush_level", b_level, 0);
    check("flush_valid", b_out_valid, 0);
    check("flush_ready", b_in_ready, 1);
    check("flush_af", b_af, 0);
    b_in_data = 32'h55;
    step();
    b_in_valid = 0;
    check("post_flush_data", b_out_data, 32'h55);
    check("post_flush_level", b_level, 1);
    b_out_ready = 1;
    step();
    check("post_flush_drain", b_level, 0);
    b_out_ready = 0;

    // Random traffic on DEPTH=3 against a scoreboard
    pushed = 0; cyc = 0; stall_prev = 0; held = 0;
    while ((pushed < 2000 || sb.size() != 0) && cyc < 20000) begin
      check("rnd_level", c_level, sb.size());
      check("rnd_in_ready", c_in_ready, sb.size() < 3);
      check("rnd_out_valid", c_out_valid, sb.size() != 0);
      if (sb.size() != 0) check("rnd_data", c_out_data, sb[0]);
      if (stall_prev) check("rnd_stable", c_out_data, held);
      c_in_valid  = (pushed < 2000) && ($urandom_range(1, 0) != 0);
      c_in_data   = 32'h1000_0000 + pushed;
      c_out_ready = ($urandom_range(1, 0) != 0);
      do_push = c_in_valid && (sb.size() < 3);
      do_pop  = c_out_ready && (sb.size() != 0);
      stall_prev = (sb.size() != 0) && !c_out_ready;
      if (sb.size() != 0) held = sb[0];
      step();
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(32'h1000_0000 + pushed);
        pushed++;
      end
      cyc++;
    end
    check("rnd_complete", (pushed == 2000) && (sb.size() == 0), 1);
    c_in_valid = 0; c_out_ready = 0;

    // Asynchronous reset mid-burst
    for (int i = 0; i < 2; i++) begin
      b_in_data = 32'h77 + i; b_in_valid = 1;
      step();
    end
    check("pre_rst_level", b_level, 2);
    b_in_data = 32'h99;
    #3;
    rstn = 0;
    #1;
    check("async_rst_ready", b_in_ready, 0);
    check("async_rst_valid", b_out_valid, 0);
    check("async_rst_level", b_level, 0);
    check("async_rst_data", b_out_data, 0);
    b_in_valid = 0;
    step();
    rstn = 1;
    step();
    check("rerelease_ready", b_in_ready, 1);
    check("rerelease_level", b_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_slice_fifo.md
Name: axi_slice_fifo

Overview:
- Parametrised successor to the single-stage valid/ready register slice.
- Decouples producer and consumer with a DEPTH-entry elastic buffer. Every output is registered: in_ready, out_valid, out_data, level and almost_full.
- Adds synchronous flush, occupancy level and almost-full reporting, and supports non-power-of-two depth.
- Used between framebuffer pipeline stages where timing closure and burst absorption both matter.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, total capacity in words including the output register (2..256, any integer)
AFULL_LEVEL, DEPTH-1, almost_full asserts when level >= AFULL_LEVEL (1..DEPTH)

Ports:
clk  in  1  clock, all logic rising-edge
rstn  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous clear of buffered contents
in_data  in  DATA_WIDTH  producer payload
in_valid  in  1  producer valid
in_ready  out  1  registered; buffer can accept a word
out_data  out  DATA_WIDTH  registered head-of-queue payload
out_valid  out  1  registered; out_data valid
out_ready  in  1  consumer ready
level  out  $clog2(DEPTH+1)  registered count of held words, 0..DEPTH
almost_full  out  1  registered, level >= AFULL_LEVEL

Behaviour:
- Reset and timing
  - Reset is asynchronous and active-low (rstn). While rstn=0: in_ready=0, out_valid=0, out_data=0, level=0, almost_full=0.
  - Storage array is not reset.
  - First rising edge after rstn deasserts: in_ready<=1. Other outputs hold their reset values.
- Handshake
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Data is transferred only on these handshakes. out_data and out_valid must not change while out_valid=1 and out_ready=0.
- Latency
  - A word pushed at edge N into an empty buffer appears with out_valid=1 after edge N. One cycle minimum, no combinational path from in_* to out_*.
- Occupancy
  - level_next = level + push - pop.
  - in_ready <= (level_next < DEPTH). This is registered, so no path from out_ready to in_ready.
  - almost_full <= (level_next >= AFULL_LEVEL).
- Throughput
  - With in_valid=1 and out_ready=1 held, one word per cycle, no bubbles, for any DEPTH >= 2.
- Full condition
  - level=DEPTH forces in_ready=0.
  - A pop at edge N gives in_ready=1 after edge N, so a push is possible in cycle N+1.
  - Push is never accepted while full.
- Empty condition
  - out_valid=0 and level=0.
  - Simultaneous push and pop are impossible when empty, since out_valid=0.
- Simultaneous push and pop, 0 < level < DEPTH
  - level is unchanged.
  - Next head is presented on the edge of the pop.
- Ordering
  - Strict FIFO.
  - Read and write pointers wrap from DEPTH-1 to 0 explicitly; no power-of-two assumption.
- Flush (flush=1 at edge N)
  - After edge N: level=0, out_valid=0, almost_full=0, in_ready=1, pointers=0.
  - Any push or pop in the flush cycle is discarded or ignored.
  - Flush has priority over push and pop.
- Reset mid-operation
  - Immediate asynchronous clear to reset values; buffered data is lost.
- Arithmetic
  - level and pointers are unsigned. Pointer width is max(1, $clog2(DEPTH)).
- Elaboration-time assertions
  - DEPTH in 2..256.
  - AFULL_LEVEL in 1..DEPTH.

Decomposition:
- Package axi_slice_pkg holds:
  - function ptr_w(depth): safe clog2 with minimum 1
  - function lvl_w(depth): clog2(depth+1)
  - localparam limits DEPTH_MIN=2, DEPTH_MAX=256
- One sub-module, axi_slice_mem: DEPTH x DATA_WIDTH simple dual-port array.
  - Write: port wr_en/wr_addr/wr_data.
  - Read: asynchronous read port.
  - No reset.
- Control, pointers, level and output register stay in axi_slice_fifo.

Test Plan:
- Reset: hold rstn=0 with in_valid=1 -> in_ready=0, out_valid=0, level=0, out_data=0. After release, in_ready=1 at first edge; no word is accepted during reset.
- Single word: DEPTH=2, push 0xA5A50001 at edge N with out_ready=1 -> out_valid=1, out_data=0xA5A50001 after N. level 1 after N, 0 after N+1.
- Fill/drain: DEPTH=4, AFULL_LEVEL=3, out_ready=0, push 1,2,3,4 -> almost_full=1 after the 3rd push, in_ready=0 and level=4 after the 4th. Raise out_ready -> 1,2,3,4 pop in order; in_ready=1 the cycle after the first pop.
- Streaming: DEPTH=2, in_valid=out_ready=1 for 100 incrementing words -> 100 consecutive pops with no bubble cycles, identical order, level stays 1.
- Random: DEPTH=3, 50% random in_valid/out_ready, 2000 words -> scoreboard exact match. level <= 3, out_data stable while stalled, pointer wrap exercised.
- Flush and mid-stream reset:
  - flush=1 at level=3 with in_valid=1 -> next cycle level=0, out_valid=0, in_ready=1, that cycle's word is dropped.
  - rstn pulsed low mid-burst -> outputs clear immediately without waiting for a clock edge.
